pfd_sampled: RTL and testbench
==============================

// Module: pfd_sampled
// PURPOSE
//  Sampled tri-state phase-frequency detector directly upstream of the PI loop filter.
//  Synchronises async reference and feedback (NCO-divided) signals into clk and detects their rising edges.
//  Drives mutually exclusive up/dn error pulses whose width in clk cycles equals the edge separation.
//  Also drives a lock indicator for status logic.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth per input, >=2
//  LOCK_WIN     4   max up/dn pulse width (cycles) counted as an in-phase event, >=1
//  LOCK_CNT     16  consecutive in-phase events required to assert lock, >=1
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous reset, active-high
//  ref_in    in   1  reference input, asynchronous to clk
//  fb_in     in   1  feedback input, asynchronous to clk
//  up        out  1  registered; high while ref leads fb (feeds loop_filter.up)
//  dn        out  1  registered; high while fb leads ref (feeds loop_filter.dn)
//  ref_edge  out  1  one-cycle pulse per qualified ref rising edge (debug/monitor)
//  fb_edge   out  1  one-cycle pulse per qualified fb rising edge
//  lock      out  1  registered lock indicator
// BEHAVIOUR
//  Reset: all sync flops, edge-delay flops, FSM (IDLE), counters, up, dn, ref_edge, fb_edge, lock <= 0.
//  Settle: after rst deasserts, edge pulses are suppressed for SYNC_STAGES+1 cycles.
//    An input held high through reset therefore produces no edge.
//  Edge detect: ref_edge = sync_last & ~sync_last_d, registered. Same for fb.
//    A rise sampled at clk edge n gives ref_edge high after edge n+SYNC_STAGES.
//  Latency: input rise -> up/dn change is SYNC_STAGES+2 clk edges.
//  FSM states and outputs: IDLE (up=0,dn=0), LEAD (up=1), LAG (dn=1).
//    up and dn are never both 1.
//  IDLE: ref_edge&~fb_edge -> LEAD; fb_edge&~ref_edge -> LAG.
//    Both edges -> stay IDLE; this is a zero-width in-phase event.
//  LEAD: fb_edge -> IDLE; ref_edge alone -> stay LEAD (extra ref edge absorbed).
//    Both edges -> stay LEAD: fb closes the old pulse, ref opens a new one.
//  LAG: mirror of LEAD with ref and fb swapped.
//  Width: ref/fb edges k cycles apart -> up (or dn) high for exactly k consecutive cycles.
//  Width counter:
//    Cleared on entry to LEAD/LAG; increments each cycle in LEAD/LAG.
//    Saturates at LOCK_WIN+1; never wraps.
//  Closure event (LEAD/LAG -> IDLE, or the LEAD/LAG "both" case):
//    good if pulse width <= LOCK_WIN, else bad. IDLE "both" case is good.
//  Lock counter:
//    Each good event increments it, saturating at LOCK_CNT.
//    A bad event clears the counter and lock on the same clk edge as the closure.
//    lock goes 1 on the clk edge where the counter reaches LOCK_CNT.
//  Reset mid-operation: the FSM returns to IDLE and up/dn drop on the reset edge.
//    Lock state is lost; settle suppression restarts.
//  Inputs with pulse or low time < 1 clk period may be missed; this is not an error condition.
// TESTING
//  T1 reset: rst=1 for 3 cycles, ref_in=fb_in=1 held -> up=dn=lock=0.
//     No ref_edge/fb_edge after release.
//  T2 ref leads fb by 5 clk -> up high exactly 5 cycles, dn=0.
//     up rises SYNC_STAGES+2 edges after the ref rise.
//  T3 fb leads ref by 3 clk -> dn high exactly 3 cycles, up=0.
//     Width-3 closure counts as good.
//  T4 ref and fb rise on the same clk, 16 periods -> up=dn=0 throughout.
//     lock=1 on the closure of the 16th period.
//  T5 locked, then ref leads by 10 clk (LOCK_WIN=4) -> up 10 cycles.
//     lock drops on the closing edge; 16 more good events are needed to relock.
//  T6 rst asserted on the 2nd cycle of a LEAD pulse -> up=0 on the next edge.
//     Next aligned edge pair after settle -> no up/dn pulse.

Source files
------------

// File: rtl/pfd_sampled.sv
// Sampled tri-state phase-frequency detector: synchronises ref/fb, detects
// rising edges, produces mutually exclusive up/dn pulses and a lock flag.
module pfd_sampled #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_WIN    = 4,
    parameter int unsigned LOCK_CNT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_in,
    input  logic fb_in,
    output logic up,
    output logic dn,
    output logic ref_edge,
    output logic fb_edge,
    output logic lock
);

    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam int unsigned WCNT_W   = $clog2(LOCK_WIN + 2);
    localparam int unsigned LCNT_W   = $clog2(LOCK_CNT + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);
    localparam logic [WCNT_W-1:0]   WCNT_MAX    = WCNT_W'(LOCK_WIN + 1);
    localparam logic [WCNT_W-1:0]   WCNT_WIN    = WCNT_W'(LOCK_WIN);
    localparam logic [LCNT_W-1:0]   LCNT_MAX    = LCNT_W'(LOCK_CNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LEAD = 2'd1;
    localparam logic [1:0] ST_LAG  = 2'd2;

    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   ref_last_d;
    logic                   fb_last_d;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   settled_c;

    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [WCNT_W-1:0]      wcnt;
    logic [WCNT_W-1:0]      wcnt_nx;
    logic [WCNT_W-1:0]      wcnt_inc_c;
    logic [LCNT_W-1:0]      lcnt;
    logic [LCNT_W-1:0]      lcnt_nx;
    logic                   lock_nx;
    logic                   evt_c;
    logic                   good_c;

    // Edge pulses stay masked until the synchronisers have flushed after reset
    assign settled_c = (settle_cnt == SETTLE_DONE);

    // Synchronisers, edge-delay flops, settle counter and registered edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_sync   <= '0;
            fb_sync    <= '0;
            ref_last_d <= 1'b0;
            fb_last_d  <= 1'b0;
            settle_cnt <= '0;
            ref_edge   <= 1'b0;
            fb_edge    <= 1'b0;
        end else begin
            ref_sync   <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            fb_sync    <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            ref_last_d <= ref_sync[SYNC_STAGES-1];
            fb_last_d  <= fb_sync[SYNC_STAGES-1];
            ref_edge   <= settled_c & ref_sync[SYNC_STAGES-1] & ~ref_last_d;
            fb_edge    <= settled_c & fb_sync[SYNC_STAGES-1] & ~fb_last_d;
            if (!settled_c) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Next-state, pulse-width tracking and lock qualification
    always_comb begin
        state_nx   = state;
        wcnt_nx    = wcnt;
        lcnt_nx    = lcnt;
        lock_nx    = lock;
        evt_c      = 1'b0;
        good_c     = 1'b0;
        wcnt_inc_c = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (ref_edge && !fb_edge) begin
                    state_nx = ST_LEAD;
                    wcnt_nx  = '0;
                end else if (fb_edge && !ref_edge) begin
                    state_nx = ST_LAG;
                    wcnt_nx  = '0;
                end else if (ref_edge && fb_edge) begin
                    evt_c  = 1'b1;
                    good_c = 1'b1;
                end
            end
            ST_LEAD: begin
                if (fb_edge) begin
                    // wcnt holds width-1 at the closing edge
                    evt_c  = 1'b1;
                    good_c = (wcnt < WCNT_WIN);
                    if (ref_edge) begin
                        wcnt_nx = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    wcnt_nx = wcnt_inc_c;
                end
            end
            ST_LAG: begin
                if (ref_edge) begin
                    evt_c  = 1'b1;
                    good_c = (wcnt < WCNT_WIN);
                    if (fb_edge) begin
                        wcnt_nx = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    wcnt_nx = wcnt_inc_c;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                wcnt_nx  = '0;
            end
        endcase

        if (evt_c) begin
            if (good_c) begin
                if (lcnt != LCNT_MAX) begin
                    lcnt_nx = lcnt + 1'b1;
                end
                lock_nx = lock | (lcnt_nx == LCNT_MAX);
            end else begin
                lcnt_nx = '0;
                lock_nx = 1'b0;
            end
        end
    end

    // State, counters and registered up/dn/lock outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            lcnt  <= '0;
            lock  <= 1'b0;
            up    <= 1'b0;
            dn    <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            lcnt  <= lcnt_nx;
            lock  <= lock_nx;
            up    <= (state_nx == ST_LEAD);
            dn    <= (state_nx == ST_LAG);
        end
    end

endmodule

// File: tb/tb_pfd_sampled.sv
// Directed testbench for pfd_sampled (SYNC_STAGES=2, LOCK_WIN=4, LOCK_CNT=16).
module tb_pfd_sampled;

    logic clk = 1'b0;
    logic rst;
    logic ref_in;
    logic fb_in;
    logic up;
    logic dn;
    logic ref_edge;
    logic fb_edge;
    logic lock;

    int checks = 0;
    int errors = 0;

    pfd_sampled #(
        .SYNC_STAGES(2),
        .LOCK_WIN   (4),
        .LOCK_CNT   (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ref_in  (ref_in),
        .fb_in   (fb_in),
        .up      (up),
        .dn      (dn),
        .ref_edge(ref_edge),
        .fb_edge (fb_edge),
        .lock    (lock)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle past the edge before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rise_at(input int d);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        return ones << d;
    endfunction

    // Apply bit i of rp/fp before step i+1, then 4 low steps; tally observed outputs
    task automatic drive_pat(input logic [31:0] rp, input logic [31:0] fp, input int len,
                             output int up_c, output int dn_c, output int both_c,
                             output int re_c, output int fe_c,
                             output int first_up, output int first_dn);
        up_c = 0; dn_c = 0; both_c = 0; re_c = 0; fe_c = 0; first_up = 0; first_dn = 0;
        for (int i = 0; i < len + 4; i++) begin
            if (i < len) begin
                ref_in = rp[i];
                fb_in  = fp[i];
            end else begin
                ref_in = 1'b0;
                fb_in  = 1'b0;
            end
            step();
            if (up === 1'b1) begin
                up_c++;
                if (first_up == 0) first_up = i + 1;
            end
            if (dn === 1'b1) begin
                dn_c++;
                if (first_dn == 0) first_dn = i + 1;
            end
            if (up === 1'b1 && dn === 1'b1) both_c++;
            if (ref_edge === 1'b1) re_c++;
            if (fb_edge === 1'b1) fe_c++;
        end
    endtask

    task automatic test_reset();
        int re_c, fe_c;
        rst = 1'b1; ref_in = 1'b1; fb_in = 1'b1;
        repeat (3) step();
        checks++; if (up !== 1'b0) begin errors++; $display("FAIL reset_up: got %b expected 0", up); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL reset_dn: got %b expected 0", dn); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", lock); end
        checks++; if (ref_edge !== 1'b0) begin errors++; $display("FAIL reset_ref_edge: got %b expected 0", ref_edge); end
        rst = 1'b0;
        re_c = 0; fe_c = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ref_edge === 1'b1) re_c++;
            if (fb_edge === 1'b1) fe_c++;
        end
        checks++; if (re_c !== 0) begin errors++; $display("FAIL reset_held_ref_edges: got %0d expected 0", re_c); end
        checks++; if (fe_c !== 0) begin errors++; $display("FAIL reset_held_fb_edges: got %0d expected 0", fe_c); end
        ref_in = 1'b0; fb_in = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_fb_lead();
        int up_c, dn_c, both_c, re_c, fe_c, fu, fd;
        drive_pat(rise_at(3), rise_at(0), 10, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (dn_c !== 3) begin errors++; $display("FAIL fb_lead_dn_width: got %0d expected 3", dn_c); end
        checks++; if (up_c !== 0) begin errors++; $display("FAIL fb_lead_up_width: got %0d expected 0", up_c); end
        checks++; if (fd !== 4) begin errors++; $display("FAIL fb_lead_latency: got %0d expected 4", fd); end
        checks++; if (both_c !== 0) begin errors++; $display("FAIL fb_lead_overlap: got %0d expected 0", both_c); end
    endtask

    task automatic test_back_to_back();
        int up_c, dn_c, both_c, re_c, fe_c, fu, fd;
        // ref rises at 0 and 3, fb at 3 and 7: one continuous 7-cycle up pulse
        drive_pat(32'hFFFF_FFFB, 32'hFFFF_FF98, 14, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (up_c !== 7) begin errors++; $display("FAIL b2b_up_width: got %0d expected 7", up_c); end
        checks++; if (dn_c !== 0) begin errors++; $display("FAIL b2b_dn_width: got %0d expected 0", dn_c); end
        checks++; if (fu !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", fu); end
        checks++; if (re_c !== 2) begin errors++; $display("FAIL b2b_ref_edges: got %0d expected 2", re_c); end
        checks++; if (fe_c !== 2) begin errors++; $display("FAIL b2b_fb_edges: got %0d expected 2", fe_c); end
    endtask

    task automatic test_ref_lead();
        int up_c, dn_c, both_c, re_c, fe_c, fu, fd;
        drive_pat(rise_at(0), rise_at(5), 12, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (up_c !== 5) begin errors++; $display("FAIL ref_lead_up_width: got %0d expected 5", up_c); end
        checks++; if (dn_c !== 0) begin errors++; $display("FAIL ref_lead_dn_width: got %0d expected 0", dn_c); end
        checks++; if (fu !== 4) begin errors++; $display("FAIL ref_lead_latency: got %0d expected 4", fu); end
    endtask

    task automatic test_lock();
        int up_c, dn_c, both_c, re_c, fe_c, fu, fd;
        int up_sum, dn_sum;
        up_sum = 0; dn_sum = 0;
        for (int p = 0; p < 15; p++) begin
            drive_pat(rise_at(0), rise_at(0), 2, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
            up_sum += up_c;
            dn_sum += dn_c;
        end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_after_15: got %b expected 0", lock); end
        checks++; if (up_sum !== 0) begin errors++; $display("FAIL lock_aligned_up: got %0d expected 0", up_sum); end
        checks++; if (dn_sum !== 0) begin errors++; $display("FAIL lock_aligned_dn: got %0d expected 0", dn_sum); end
        ref_in = 1'b1; fb_in = 1'b1;
        repeat (3) step();
        checks++; if (ref_edge !== 1'b1) begin errors++; $display("FAIL lock_16_ref_edge: got %b expected 1", ref_edge); end
        checks++; if (fb_edge !== 1'b1) begin errors++; $display("FAIL lock_16_fb_edge: got %b expected 1", fb_edge); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_before_closure: got %b expected 0", lock); end
        step();
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL lock_on_closure: got %b expected 1", lock); end
        checks++; if ({up, dn} !== 2'b00) begin errors++; $display("FAIL lock_16_updn: got %b expected 00", {up, dn}); end
        ref_in = 1'b0; fb_in = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_unlock();
        int up_c, dn_c, both_c, re_c, fe_c, fu, fd;
        drive_pat(rise_at(0), rise_at(10), 16, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (up_c !== 10) begin errors++; $display("FAIL unlock_up_width: got %0d expected 10", up_c); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL unlock_lock: got %b expected 0", lock); end
        for (int p = 0; p < 15; p++) begin
            drive_pat(rise_at(0), rise_at(0), 2, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL relock_after_15: got %b expected 0", lock); end
        drive_pat(rise_at(0), rise_at(0), 2, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL relock_after_16: got %b expected 1", lock); end
        // Width exactly LOCK_WIN is still an in-phase event
        drive_pat(rise_at(0), rise_at(4), 10, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (up_c !== 4) begin errors++; $display("FAIL win_edge_up_width: got %0d expected 4", up_c); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL win_edge_lock: got %b expected 1", lock); end
    endtask

    task automatic test_reset_mid();
        int up_c, dn_c, both_c, re_c, fe_c, fu, fd;
        ref_in = 1'b1; fb_in = 1'b0;
        repeat (4) step();
        checks++; if (up !== 1'b1) begin errors++; $display("FAIL mid_up_first: got %b expected 1", up); end
        step();
        checks++; if (up !== 1'b1) begin errors++; $display("FAIL mid_up_second: got %b expected 1", up); end
        rst = 1'b1;
        step();
        checks++; if (up !== 1'b0) begin errors++; $display("FAIL mid_rst_up: got %b expected 0", up); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL mid_rst_dn: got %b expected 0", dn); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL mid_rst_lock: got %b expected 0", lock); end
        rst = 1'b0; ref_in = 1'b0;
        repeat (5) step();
        drive_pat(rise_at(0), rise_at(0), 4, up_c, dn_c, both_c, re_c, fe_c, fu, fd);
        checks++; if (up_c !== 0) begin errors++; $display("FAIL mid_aligned_up: got %0d expected 0", up_c); end
        checks++; if (dn_c !== 0) begin errors++; $display("FAIL mid_aligned_dn: got %0d expected 0", dn_c); end
        checks++; if (re_c !== 1) begin errors++; $display("FAIL mid_aligned_ref_edges: got %0d expected 1", re_c); end
        checks++; if (fe_c !== 1) begin errors++; $display("FAIL mid_aligned_fb_edges: got %0d expected 1", fe_c); end
    endtask

    initial begin
        rst = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
        test_reset();
        test_fb_lead();
        test_back_to_back();
        test_ref_lead();
        test_lock();
        test_unlock();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
